// File: rtl/seq_pkg.sv
// Shared types and constants for the 1101 sequence serializer/detector pair.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } ser_state_t;

    localparam logic       IDLE_BIT_DEF = 1'b0;
    localparam logic [3:0] PATTERN_1101 = 4'b1101;

    // Counter width for a range of 'range' values, never narrower than 1 bit.
    function automatic int cnt_width(input int range);
        return (range > 1) ? $clog2(range) : 1;
    endfunction

endpackage

// File: rtl/seq_bit_serializer_if.sv
// Parallel-word handshake in, serial bit stream and frame markers out.
interface seq_bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             frame_start;
    logic             frame_last;
    logic             busy;

    modport master (
        output in_data, in_valid,
        input  in_ready, ser_out, ser_valid, frame_start, frame_last, busy
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, ser_out, ser_valid, frame_start, frame_last, busy
    );
endinterface

// File: rtl/seq_down_counter.sv
// Loadable down-counter with a zero flag; load has priority over decrement.
module seq_down_counter #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         zero
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    cnt <= '0;
        else if (load) cnt <= load_val;
        else if (dec)  cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/seq_bit_serializer.sv
// Serializes handshaked parallel words one bit per clock, with an optional
// idle gap after each frame; feeds the 1101 detector's din.
module seq_bit_serializer
    import seq_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter bit   LSB_FIRST  = 1'b0,
    parameter int   GAP_CYCLES = 0,
    parameter logic IDLE_BIT   = IDLE_BIT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    seq_bit_serializer_if.slave bus
);

    localparam int BW = cnt_width(WIDTH);
    localparam int GW = cnt_width(GAP_CYCLES);
    localparam logic [BW-1:0] BIT_LOAD = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    ser_state_t       state, next_state;
    logic [WIDTH-1:0] sr, sr_d;
    logic             ser_out_q, ser_valid_q, start_q, last_q;
    logic             ser_out_d, ser_valid_d, start_d, last_d;
    logic             ready, take;

    logic [BW-1:0]    bit_cnt;
    logic             bit_zero;
    logic [GW-1:0]    gap_cnt;
    logic             gap_zero;
    logic             unused_gap;

    // Bit counter holds the number of frame bits still to be launched.
    seq_down_counter #(.W(BW)) u_bit_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (take),
        .dec      (state == SHIFT && !bit_zero),
        .load_val (BIT_LOAD),
        .cnt      (bit_cnt),
        .zero     (bit_zero)
    );

    seq_down_counter #(.W(GW)) u_gap_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (state == SHIFT && bit_zero && GAP_CYCLES > 0),
        .dec      (state == GAP && !gap_zero),
        .load_val (GAP_LOAD),
        .cnt      (gap_cnt),
        .zero     (gap_zero)
    );

    assign unused_gap = ^gap_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            sr          <= '0;
            ser_out_q   <= IDLE_BIT;
            ser_valid_q <= 1'b0;
            start_q     <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state       <= next_state;
            sr          <= sr_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            start_q     <= start_d;
            last_q      <= last_d;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (take) next_state = SHIFT;
            SHIFT: begin
                if (bit_zero) begin
                    if (GAP_CYCLES > 0) next_state = GAP;
                    else                next_state = take ? SHIFT : IDLE;
                end
            end
            GAP:   if (gap_zero) next_state = take ? SHIFT : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // in_ready depends only on state, counters and reset, never on in_valid.
    always_comb begin
        ready = 1'b0;
        case (state)
            IDLE:    ready = 1'b1;
            SHIFT:   ready = bit_zero && (GAP_CYCLES == 0);
            GAP:     ready = gap_zero;
            default: ready = 1'b0;
        endcase
        ready = ready && reset;
        take  = bus.in_valid && ready;

        sr_d        = sr;
        ser_out_d   = IDLE_BIT;
        ser_valid_d = 1'b0;
        start_d     = 1'b0;
        last_d      = 1'b0;
        if (take) begin
            ser_out_d   = LSB_FIRST ? bus.in_data[0] : bus.in_data[WIDTH-1];
            ser_valid_d = 1'b1;
            start_d     = 1'b1;
            sr_d        = LSB_FIRST ? (bus.in_data >> 1) : (bus.in_data << 1);
        end else if (state == SHIFT && !bit_zero) begin
            ser_out_d   = LSB_FIRST ? sr[0] : sr[WIDTH-1];
            ser_valid_d = 1'b1;
            last_d      = (bit_cnt == BW'(1));
            sr_d        = LSB_FIRST ? (sr >> 1) : (sr << 1);
        end
    end

    assign bus.in_ready    = ready;
    assign bus.ser_out     = ser_out_q;
    assign bus.ser_valid   = ser_valid_q;
    assign bus.frame_start = start_q;
    assign bus.frame_last  = last_q;
    assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Two serializer configurations (4-bit MSB-first no gap, 8-bit LSB-first gap 3)
// checked against an occupancy/bit-queue reference model.
module tb_seq_bit_serializer;
    import seq_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [7:0] drv_data [2];
    logic [1:0] drv_valid;
    logic [1:0] rdy, sv_mon, so_mon;
    int         errors = 0;
    int         checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t got %0h expected %0h", name, g, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : h
        localparam int W = (g == 0) ? 4 : 8;
        localparam bit LSB = (g == 0) ? 1'b0 : 1'b1;
        localparam int G = (g == 0) ? 0 : 3;

        seq_bit_serializer_if #(.WIDTH(W)) bus ();

        seq_bit_serializer #(
            .WIDTH(W), .LSB_FIRST(LSB), .GAP_CYCLES(G), .IDLE_BIT(1'b0)
        ) dut (
            .clk   (clk),
            .reset (rst_n),
            .bus   (bus)
        );

        assign bus.in_data  = drv_data[g][W-1:0];
        assign bus.in_valid = drv_valid[g];
        assign rdy[g]       = bus.in_ready;
        assign sv_mon[g]    = bus.ser_valid;
        assign so_mon[g]    = bus.ser_out;

        // occ = cycles the block stays occupied (W frame bits then G idle bits).
        initial begin : model_mon
            int         occ;
            bit         sv;
            logic [2:0] q[$];
            logic [2:0] e;
            logic [7:0] d;
            occ = 0;
            forever begin
                @(posedge clk);
                if (!rst_n) begin
                    occ = 0;
                    q.delete();
                end else if (drv_valid[g] && occ <= 1) begin
                    d = drv_data[g];
                    for (int i = 0; i < W; i++)
                        q.push_back({(LSB ? d[i] : d[W-1-i]), (i == 0), (i == W-1)});
                    occ = W + G;
                end else if (occ > 0) begin
                    occ--;
                end
                @(negedge clk);
                if (!rst_n) begin
                    occ = 0;
                    q.delete();
                    chk("rst_in_ready", g, bus.in_ready, 0);
                    chk("rst_ser_valid", g, bus.ser_valid, 0);
                    chk("rst_ser_out", g, bus.ser_out, 0);
                    chk("rst_busy", g, bus.busy, 0);
                    chk("rst_pulses", g, {bus.frame_start, bus.frame_last}, 0);
                end else begin
                    sv = (occ > 0) && ((W + G - occ) < W);
                    chk("in_ready", g, bus.in_ready, (occ <= 1));
                    chk("busy", g, bus.busy, (occ > 0));
                    chk("ser_valid", g, bus.ser_valid, sv);
                    if (sv) begin
                        if (q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL scoreboard dut%0d t=%0t got bit with empty queue", g, $time);
                        end else begin
                            e = q.pop_front();
                            chk("ser_out", g, bus.ser_out, e[2]);
                            chk("frame_start", g, bus.frame_start, e[1]);
                            chk("frame_last", g, bus.frame_last, e[0]);
                        end
                    end else begin
                        chk("idle_ser_out", g, bus.ser_out, 0);
                        chk("idle_pulses", g, {bus.frame_start, bus.frame_last}, 0);
                    end
                end
            end
        end
    end

    // Entered and left at a falling edge; returns after the accepting rising edge.
    task automatic send(input int g, input logic [7:0] d);
        int   n;
        logic r;
        drv_data[g]  = d;
        drv_valid[g] = 1'b1;
        n = 0;
        do begin
            r = rdy[g];
            @(negedge clk);
            n++;
        end while (!r && n < 64);
        checks++;
        if (!r) begin
            errors++;
            $display("FAIL send_timeout dut%0d data=%0h", g, d);
        end
    endtask

    task automatic rand_run(input int g, input int n);
        for (int i = 0; i < n; i++) begin
            send(g, 8'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                drv_valid[g] = 1'b0;
                repeat ($urandom_range(0, 5)) @(negedge clk);
            end
        end
        drv_valid[g] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        drv_valid   = 2'b00;
        drv_data[0] = 8'h00;
        drv_data[1] = 8'h00;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        // quiet period: nothing offered
        repeat (20) @(negedge clk);

        // single 1101 frame, then back-to-back pair
        send(0, {4'h0, PATTERN_1101});
        drv_valid[0] = 1'b0;
        repeat (6) @(negedge clk);
        send(0, {4'h0, PATTERN_1101});
        send(0, {4'h0, PATTERN_1101});
        drv_valid[0] = 1'b0;
        repeat (6) @(negedge clk);

        // LSB-first A5, then two words across the 3-cycle gap
        send(1, 8'hA5);
        drv_valid[1] = 1'b0;
        repeat (14) @(negedge clk);
        send(1, 8'h3C);
        send(1, 8'hC3);
        drv_valid[1] = 1'b0;
        repeat (14) @(negedge clk);

        fork
            rand_run(0, 40);
            rand_run(1, 40);
        join
        repeat (16) @(negedge clk);

        // reset asserted while bit 2 of FF is on the line
        send(1, 8'hFF);
        drv_valid[1] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("pre_reset_ser_valid", 1, sv_mon[1], 1);
        rst_n = 1'b0;
        #1;
        chk("async_ser_valid", 1, sv_mon[1], 0);
        chk("async_ser_out", 1, so_mon[1], 0);
        chk("async_in_ready", 1, rdy[1], 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("post_reset_in_ready", 1, rdy[1], 1);
        repeat (12) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
